grf_write_arbiter: RTL

Arbitrates the single GRF write port between the pipeline W-stage writeback and an auxiliary result source (multi-cycle MDU / CP0 return path) that delivers results out of step with the pipeline. The pipeline always has priority. Auxiliary results are buffered in a small FIFO and drained into free write-port cycles. The block also reports pending-write hazards to the decode stage and requests a pipeline bubble when an auxiliary result starves.

---
 rtl/grf_write_arbiter_pkg.sv | 16 +
 rtl/grf_write_arbiter_if.sv | 39 +++
 rtl/grf_write_arbiter_wb_fifo.sv | 71 +++++++
 rtl/grf_write_arbiter.sv | 83 ++++++++
 4 files changed

// File: rtl/grf_write_arbiter_pkg.sv
// Shared types and defaults for the GRF write-port arbiter and its auxiliary FIFO.
package grf_write_arbiter_pkg;
    localparam int DEPTH_DEF    = 2;
    localparam int MAX_WAIT_DEF = 4;
    localparam int AW           = 5;
    localparam int DW           = 32;
    localparam int PCW          = 32;
    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic           live;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        logic [PCW-1:0] pc;
    } wb_entry_t;
endpackage

// File: rtl/grf_write_arbiter_if.sv
// Pipeline, auxiliary, GRF and decode-hazard signals of the write arbiter.
interface grf_write_arbiter_if;
    import grf_write_arbiter_pkg::*;

    logic           pipe_we;
    logic [AW-1:0]  pipe_addr;
    logic [DW-1:0]  pipe_data;
    logic [PCW-1:0] pipe_pc;
    logic           aux_valid;
    logic           aux_ready;
    logic [AW-1:0]  aux_addr;
    logic [DW-1:0]  aux_data;
    logic [PCW-1:0] aux_pc;
    logic           grf_we;
    logic [AW-1:0]  grf_addr;
    logic [DW-1:0]  grf_data;
    logic [PCW-1:0] grf_pc;
    logic [AW-1:0]  rd_addr1;
    logic [AW-1:0]  rd_addr2;
    logic           rd1_pending;
    logic           rd2_pending;
    logic           stall;

    modport master (
        output pipe_we, pipe_addr, pipe_data, pipe_pc,
        output aux_valid, aux_addr, aux_data, aux_pc,
        output rd_addr1, rd_addr2,
        input  aux_ready, grf_we, grf_addr, grf_data, grf_pc,
        input  rd1_pending, rd2_pending, stall
    );

    modport slave (
        input  pipe_we, pipe_addr, pipe_data, pipe_pc,
        input  aux_valid, aux_addr, aux_data, aux_pc,
        input  rd_addr1, rd_addr2,
        output aux_ready, grf_we, grf_addr, grf_data, grf_pc,
        output rd1_pending, rd2_pending, stall
    );
endinterface

// File: rtl/grf_write_arbiter_wb_fifo.sv
// Auxiliary writeback FIFO with per-entry live bits, kill-by-address and address match.
module grf_wb_fifo
    import grf_write_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    input  logic             kill,
    input  logic [AW-1:0]    kill_addr,
    input  logic [AW-1:0]    q_addr1,
    input  logic [AW-1:0]    q_addr2,
    output wb_entry_t        head,
    output logic             head_vld,
    output logic [CW-1:0]    count,
    output logic [DEPTH-1:0] match1,
    output logic [DEPTH-1:0] match2
);
    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [PCW-1:0]   pc_q   [DEPTH];
    logic [DEPTH-1:0] live;
    logic [PW-1:0]    wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            live   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (kill && addr_q[i] == kill_addr) live[i] <= 1'b0;
            // pop and push never share a slot: push needs a free slot, pop a filled one
            if (pop) begin
                live[rd_ptr] <= 1'b0;
                rd_ptr       <= rd_ptr + 1'b1;
            end
            if (push) begin
                live[wr_ptr] <= push_entry.live;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= push_entry.addr;
            data_q[wr_ptr] <= push_entry.data;
            pc_q[wr_ptr]   <= push_entry.pc;
        end
    end

    assign head_vld = (count != '0);
    assign head     = '{live: live[rd_ptr], addr: addr_q[rd_ptr],
                        data: data_q[rd_ptr], pc: pc_q[rd_ptr]};

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match1[i] = live[i] && (addr_q[i] == q_addr1);
            match2[i] = live[i] && (addr_q[i] == q_addr2);
        end
    end
endmodule

// File: rtl/grf_write_arbiter.sv
// GRF write-port arbiter: pipeline first, buffered auxiliary results drain into idle cycles.
module grf_write_arbiter
    import grf_write_arbiter_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input logic clk,
    input logic reset,
    grf_write_arbiter_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(MAX_WAIT + 1);

    wb_entry_t        head, push_entry;
    logic             head_vld, push, pop, pipe_act, head_wr, lose;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] match1, match2;
    logic [SW-1:0]    wait_cnt;
    logic             stall_q;

    assign pipe_act   = bus.pipe_we && (bus.pipe_addr != REG_ZERO);
    assign bus.aux_ready = (count != CW'(DEPTH));
    assign push       = bus.aux_valid && bus.aux_ready;
    assign push_entry = '{live: (bus.aux_addr != REG_ZERO), addr: bus.aux_addr,
                          data: bus.aux_data, pc: bus.aux_pc};
    assign head_wr    = !pipe_act && head_vld && head.live;
    // dead heads drain even while the pipe owns the port
    assign pop        = head_vld && (!head.live || !pipe_act);
    assign lose       = head_vld && head.live && pipe_act;

    grf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill       (pipe_act),
        .kill_addr  (bus.pipe_addr),
        .q_addr1    (bus.rd_addr1),
        .q_addr2    (bus.rd_addr2),
        .head       (head),
        .head_vld   (head_vld),
        .count      (count),
        .match1     (match1),
        .match2     (match2)
    );

    always_comb begin
        bus.grf_we   = 1'b0;
        bus.grf_addr = '0;
        bus.grf_data = '0;
        bus.grf_pc   = '0;
        if (pipe_act) begin
            bus.grf_we   = 1'b1;
            bus.grf_addr = bus.pipe_addr;
            bus.grf_data = bus.pipe_data;
            bus.grf_pc   = bus.pipe_pc;
        end else if (head_wr) begin
            bus.grf_we   = 1'b1;
            bus.grf_addr = head.addr;
            bus.grf_data = head.data;
            bus.grf_pc   = head.pc;
        end
    end

    assign bus.rd1_pending = (|match1) && (bus.rd_addr1 != REG_ZERO);
    assign bus.rd2_pending = (|match2) && (bus.rd_addr2 != REG_ZERO);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            stall_q  <= 1'b0;
        end else begin
            if (pop)                                   wait_cnt <= '0;
            else if (lose && wait_cnt < SW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
            if (pop)                                   stall_q <= 1'b0;
            else if (wait_cnt == SW'(MAX_WAIT))        stall_q <= 1'b1;
        end
    end

    assign bus.stall = stall_q;
endmodule
